// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - access size decode and alignment helpers
//   - FSM state type for lsu_ctrl
package lsu_pkg;

  localparam int unsigned NumLanes = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // funct3[1:0] carries the size; the unused encodings (011/110/111) fall to word.
  function automatic size_e f3_size(logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e sz, logic [1:0] off);
    case (sz)
      SzHalf:  return off[0];
      SzWord:  return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Rounds the byte offset down to the natural alignment of the access.
  function automatic logic [1:0] force_align(size_e sz, logic [1:0] off);
    case (sz)
      SzHalf:  return {off[1], 1'b0};
      SzWord:  return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: CPU-side request/response and memory-side bus of the load/store unit.
//   slave  : seen by lsu_ctrl (takes CPU request and memory response, drives the rest)
//   master : seen by the environment (CPU datapath plus data memory)
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  stall;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  bus_err;
  logic                  fault;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, rsp_valid, rsp_rdata, bus_err, fault, mem_req, mem_we, mem_addr, mem_be,
           mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, bus_err, fault, mem_req, mem_we, mem_addr, mem_be,
           mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering.
//   funct3_i  : access type          offset_i  : byte offset within the word
//   st_data_i : right-aligned store  be_o / st_data_o : byte enables and lane-shifted store data
//   ld_word_i : raw memory word      ld_data_o : selected lane, sign/zero extended
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  size_e       size;
  logic        sext;
  logic [31:0] ld_shift;

  always_comb begin
    size      = f3_size(funct3_i);
    sext      = ~funct3_i[2];
    be_o      = 4'b1111;
    st_data_o = st_data_i;
    ld_shift  = ld_word_i;
    ld_data_o = ld_word_i;
    case (size)
      SzByte: begin
        be_o      = 4'b0001 << offset_i;
        st_data_o = {24'b0, st_data_i[7:0]} << {offset_i, 3'b000};
        ld_shift  = ld_word_i >> {offset_i, 3'b000};
        ld_data_o = {{24{sext & ld_shift[7]}}, ld_shift[7:0]};
      end
      SzHalf: begin
        be_o      = 4'b0011 << {offset_i[1], 1'b0};
        st_data_o = {16'b0, st_data_i[15:0]} << {offset_i[1], 4'b0000};
        ld_shift  = ld_word_i >> {offset_i[1], 4'b0000};
        ld_data_o = {{16{sext & ld_shift[15]}}, ld_shift[15:0]};
      end
      default: begin
        be_o      = 4'b1111;
        st_data_o = st_data_i;
        ld_data_o = ld_word_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the CPU datapath and a multi-cycle data memory.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : lsu_if.slave (CPU request/response, memory request/ack)
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (fault pulse, no memory request). Otherwise misaligned addresses are rounded down.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic  clk_i,
  input logic  rst_ni,
  lsu_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                  fault_q, fault_d;
`endif

  size_e       req_size;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  lsu_lane_align u_align (
    .funct3_i  (f3_q),
    .offset_i  (addr_q[1:0]),
    .st_data_i (wdata_q),
    .be_o      (be),
    .st_data_o (st_data),
    .ld_word_i (bus.mem_rdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    f3_d     = f3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    req_size = f3_size(bus.req_funct3);
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Rounding is a no-op for aligned addresses, so trap mode can share it.
          addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], force_align(req_size, bus.req_addr[1:0])};
          f3_d    = bus.req_funct3;
          we_d    = bus.req_write;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = BUSY;
`ifdef LSU_MISALIGN_TRAP_EN
          fault_d = 1'b0;
          if (is_misaligned(req_size, bus.req_addr[1:0])) begin
            fault_d = 1'b1;
            rdata_d = '0;
            we_d    = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus.mem_ack) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    // Gated by reset so an access cut off by reset releases the PC immediately.
    bus.stall     = rst_ni & (((state_q == IDLE) & bus.req_valid) | (state_q == BUSY));
    bus.mem_req   = (state_q == BUSY);
    bus.mem_we    = (state_q == BUSY) & we_q;
    bus.mem_be    = (state_q == BUSY) ? be : 4'b0000;
    bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus.mem_wdata = st_data;
    bus.rsp_valid = (state_q == DONE);
    bus.rsp_rdata = rdata_q;
    bus.bus_err   = (state_q == DONE) & err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    bus.fault     = (state_q == DONE) & fault_q;
`else
    bus.fault     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_ctrl #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rules, expressed as byte arithmetic.
  function automatic int sz_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input int nb);
    return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
  endfunction

  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword, input int delay);
    int          nb;
    int          off;
    bit          mis;
    bit          trap;
    bit          tmo;
    logic [31:0] ea;
    logic [31:0] e_be;
    logic [31:0] e_wd;
    logic [31:0] v;
    nb   = sz_bytes(f3);
    mis  = (addr % nb) != 0;
    ea   = addr - (addr % nb);
    off  = ea % 4;
    e_be = ((1 << nb) - 1) << off;
    e_wd = (wdata & lane_mask(nb)) << (8 * off);
    v    = (rword >> (8 * off)) & lane_mask(nb);
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*nb-1]) v = v | ~lane_mask(nb);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    tmo = (delay < 0) || (delay >= TO);

    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_ack    = 1'b0;
    @(negedge clk);
    check_eq("idle_stall", bus.stall, 1);
    check_eq("idle_mem_req", bus.mem_req, 0);
    @(posedge clk); #1;
    if (!trap) begin
      for (int n = 0; n < TO; n++) begin
        bus.mem_ack   = (n == delay);
        bus.mem_rdata = (n == delay) ? rword : $urandom;
        @(negedge clk);
        check_eq("busy_mem_req", bus.mem_req, 1);
        check_eq("busy_stall", bus.stall, 1);
        check_eq("busy_rsp_valid", bus.rsp_valid, 0);
        check_eq("busy_mem_we", bus.mem_we, wr);
        check_eq("busy_mem_addr", bus.mem_addr, ea & 32'hFFFF_FFFC);
        check_eq("busy_mem_be", bus.mem_be, e_be);
        if (wr) check_eq("busy_mem_wdata", bus.mem_wdata, e_wd);
        if (n == delay || n == TO - 1) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    // Ack in DONE must be ignored; req_valid stays high for the same instruction.
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    @(negedge clk);
    check_eq("done_rsp_valid", bus.rsp_valid, 1);
    check_eq("done_stall", bus.stall, 0);
    check_eq("done_mem_req", bus.mem_req, 0);
    check_eq("done_bus_err", bus.bus_err, (!trap && tmo) ? 1 : 0);
    check_eq("done_fault", bus.fault, trap ? 1 : 0);
    if (trap || tmo) check_eq("done_rdata_zero", bus.rsp_rdata, 0);
    else if (!wr) check_eq("done_rdata", bus.rsp_rdata, v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("after_rsp_valid", bus.rsp_valid, 0);
    check_eq("after_stall", bus.stall, 0);
    check_eq("after_mem_req", bus.mem_req, 0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
  endtask

  task automatic reset_mid_access();
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0200;
    bus.mem_ack    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_pre_mem_req", bus.mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_rdata", bus.rsp_rdata, 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("late_ack_rsp_valid", bus.rsp_valid, 0);
    check_eq("late_ack_mem_req", bus.mem_req, 0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_rsp_valid2", bus.rsp_valid, 0);
    check_eq("late_ack_stall", bus.stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] ld_f3 [8];
    logic [2:0] f3;
    logic       wr;
    int         dly;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    #12;
    check_eq("reset_stall", bus.stall, 0);
    check_eq("reset_rsp_valid", bus.rsp_valid, 0);
    check_eq("reset_bus_err", bus.bus_err, 0);
    check_eq("reset_fault", bus.fault, 0);
    check_eq("reset_mem_req", bus.mem_req, 0);
    check_eq("reset_mem_we", bus.mem_we, 0);
    check_eq("reset_mem_be", bus.mem_be, 0);
    check_eq("reset_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("reset_mem_addr", bus.mem_addr, 0);
    check_eq("reset_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
    run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 1);
    run_txn(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 0);
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hF00F_1234, 4);
    run_txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h9abc_1234, 2);
    run_txn(1'b1, 3'b000, 32'h0000_0301, 32'hFFFF_FFA5, 32'h0, 3);
    run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1111_2222, -1);
    run_txn(1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'h3333_4444, TO - 1);
    run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h5555_6666, 0);
    run_txn(1'b1, 3'b001, 32'h0000_0103, 32'hABCD_5678, 32'h0, 0);
    reset_mid_access();
    run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 300; i++) begin
      wr  = 1'($urandom_range(0, 1));
      f3  = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
      run_txn(wr, f3, $urandom, $urandom, $urandom, dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
